pwm_gen: RTL and testbench
==========================

PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 Parameter PRESCALE_MAX, default 8'd49, prescaler terminal count; one PWM step per PRESCALE_MAX+1 clocks.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 clock  input  1  main clock; all state updates on rising edge.
REQ-004 pwm_enable  input  1  high = generate PWM; low = output forced low, counters held.
REQ-005 pwm_update  input  1  level request to load pwm_ratio; held until pwm_done observed high.
REQ-006 pwm_ratio  input  8  requested high-time out of 255; 128 = motor neutral.
REQ-007 pwm_done  output  1  level acknowledge that the requested ratio is now active.
REQ-008 pwm_signal  output  1  registered PWM waveform to motor driver.
REQ-009 period_start  output  1  one-clock pulse in the cycle step counter returns to 0.

Function
REQ-010 Prescaler SHALL count 0..PRESCALE_MAX, wrap to 0, and assert internal tick in the cycle it equals PRESCALE_MAX.
REQ-011 Step counter SHALL be 8 bits, advance only on tick, count 0..254, and wrap 254 -> 0 (255 steps per period).
REQ-012 Period boundary SHALL be defined as tick AND step counter == 254; period_start SHALL be registered high the following cycle, for exactly one clock.
REQ-013 pwm_signal SHALL be registered as (pwm_enable AND step counter < active ratio): one clock latency from counter; ratio 0 = always low, ratio 255 = always high.
REQ-014 Handshake FSM states: IDLE, PENDING, DONE.
REQ-015 IDLE: pwm_update high SHALL capture pwm_ratio into shadow register and move to PENDING; pwm_done low.
REQ-016 PENDING: on period boundary (or any cycle with pwm_enable low) shadow SHALL copy to active ratio and FSM SHALL move to DONE; pwm_ratio changes while PENDING SHALL be ignored.
REQ-017 DONE: pwm_done SHALL be high; when pwm_update low, move to IDLE with pwm_done low the next cycle.
REQ-018 pwm_update deasserted while PENDING SHALL NOT abort; ratio still applied, DONE held one cycle, then IDLE.
REQ-019 Capture coinciding with a period boundary SHALL apply at the NEXT boundary, never the same one.
REQ-020 Active ratio SHALL change only at a period boundary while enabled (glitch-free periods).
REQ-021 pwm_enable low SHALL clear prescaler and step counter to 0 and drive pwm_signal low next cycle; active ratio retained; re-enable starts a full period at step 0.

Reset
REQ-022 On reset_n low, asynchronously: pwm_signal 0, pwm_done 0, period_start 0, FSM IDLE, prescaler 0, step counter 0, active and shadow ratio 8'd128.
REQ-023 Reset mid-PENDING SHALL discard the shadow value; first post-reset request is handled from IDLE.

Structure
REQ-024 Shared package pwm_pkg SHALL hold PWM_NEUTRAL (8'd128), PWM_STEP_MAX (8'd254), and handshake state encodings.
REQ-025 Prescaler SHALL be a sub-module pwm_tick_gen (parameter PRESCALE_MAX, outputs tick); all else in pwm_gen.

Verification (PRESCALE_MAX = 0 unless stated)
REQ-026 Reset release, enable high, no update -> pwm_signal high 128 clocks, low 127 clocks, repeating; period_start every 255 clocks.
REQ-027 pwm_update with ratio 200 mid-period -> pwm_done rises cycle after next boundary; following period high 200 / low 55; drop update -> pwm_done low next cycle.
REQ-028 Ratios 0 and 255 applied in turn -> pwm_signal constantly low for a full period, then constantly high.
REQ-029 Request ratio 50 captured in boundary cycle -> current period stays at old ratio, 50 active one full period later; pwm_ratio changed to 10 while PENDING has no effect.
REQ-030 pwm_enable low with update PENDING -> pwm_done high within 2 clocks, pwm_signal low; re-enable -> period restarts at step 0 with new ratio.
REQ-031 PRESCALE_MAX = 3, ratio 64 -> high 256 clocks, low 764 clocks; reset asserted mid-high -> pwm_signal 0 immediately, ratio 128 after release.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and handshake state encoding
// for the motor PWM generator.
package pwm_pkg;

  localparam logic [7:0] PWM_NEUTRAL  = 8'd128;
  localparam logic [7:0] PWM_STEP_MAX = 8'd254;

  typedef enum logic [1:0] {
    HS_IDLE    = 2'd0,
    HS_PENDING = 2'd1,
    HS_DONE    = 2'd2
  } hs_state_e;

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler: one tick every PRESCALE_MAX+1 enabled clocks,
// cleared and silent while disabled.
module pwm_tick_gen #(
  parameter logic [7:0] PRESCALE_MAX = 8'd49
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable_i,
  output logic tick_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    tick_o  = enable_i && (count_q == PRESCALE_MAX);
    count_d = count_q;
    if (!enable_i || tick_o) begin
      count_d = '0;
    end else begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pwm_gen.sv
// 255-step motor PWM generator with a level request/acknowledge
// ratio update that only takes effect on period boundaries.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter logic [7:0] PRESCALE_MAX = 8'd49
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pwm_enable,
  input  logic       pwm_update,
  input  logic [7:0] pwm_ratio,
  output logic       pwm_done,
  output logic       pwm_signal,
  output logic       period_start
);

  logic       tick;
  logic       boundary;
  logic [7:0] step_q;
  logic [7:0] step_d;
  logic [7:0] active_q;
  logic [7:0] active_d;
  logic [7:0] shadow_q;
  logic [7:0] shadow_d;
  logic       sig_q;
  logic       ps_q;
  hs_state_e  state_q;
  hs_state_e  state_d;

  pwm_tick_gen #(
    .PRESCALE_MAX(PRESCALE_MAX)
  ) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .enable_i(pwm_enable),
    .tick_o  (tick)
  );

  assign boundary = tick && (step_q == PWM_STEP_MAX);

  always_comb begin
    step_d = step_q;
    if (!pwm_enable) begin
      step_d = '0;
    end else if (tick) begin
      step_d = boundary ? 8'd0 : step_q + 8'd1;
    end
  end

  // A capture in a boundary cycle lands in PENDING after that edge,
  // so it can only be applied at the following boundary.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    shadow_d = shadow_q;
    unique case (state_q)
      HS_IDLE: begin
        if (pwm_update) begin
          shadow_d = pwm_ratio;
          state_d  = HS_PENDING;
        end
      end
      HS_PENDING: begin
        if (boundary || !pwm_enable) begin
          active_d = shadow_q;
          state_d  = HS_DONE;
        end
      end
      HS_DONE: begin
        if (!pwm_update) begin
          state_d = HS_IDLE;
        end
      end
      default: state_d = HS_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= HS_IDLE;
      step_q   <= '0;
      active_q <= PWM_NEUTRAL;
      shadow_q <= PWM_NEUTRAL;
      sig_q    <= 1'b0;
      ps_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      sig_q    <= pwm_enable && (step_q < active_q);
      ps_q     <= boundary;
    end
  end

  assign pwm_done     = (state_q == HS_DONE);
  assign pwm_signal   = sig_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_gen.sv
// Bench for pwm_gen: elapsed-time reference model on a PRESCALE_MAX=0
// instance plus run-length checks on a PRESCALE_MAX=3 instance.
module tb_pwm_gen;

  localparam int MP = 0;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       pwm_enable;
  logic       pwm_update;
  logic [7:0] pwm_ratio;
  logic       pwm_done;
  logic       pwm_signal;
  logic       period_start;

  logic       r3_n;
  logic       en3;
  logic       upd3;
  logic [7:0] rat3;
  logic       done3;
  logic       sig3;
  logic       ps3;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: time since enable, request flags, ratios
  int elapsed;
  bit m_pend;
  bit m_done;
  int m_active;
  int m_shadow;
  bit e_sig;
  bit e_ps;

  always #5 clock = ~clock;

  pwm_gen #(.PRESCALE_MAX(8'd0)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pwm_enable  (pwm_enable),
    .pwm_update  (pwm_update),
    .pwm_ratio   (pwm_ratio),
    .pwm_done    (pwm_done),
    .pwm_signal  (pwm_signal),
    .period_start(period_start)
  );

  pwm_gen #(.PRESCALE_MAX(8'd3)) dut3 (
    .clock       (clock),
    .reset_n     (r3_n),
    .pwm_enable  (en3),
    .pwm_update  (upd3),
    .pwm_ratio   (rat3),
    .pwm_done    (done3),
    .pwm_signal  (sig3),
    .period_start(ps3)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    elapsed  = 0;
    m_pend   = 0;
    m_done   = 0;
    m_active = 128;
    m_shadow = 128;
    e_sig    = 0;
    e_ps     = 0;
  endtask

  task automatic cyc();
    bit tk;
    bit bd;
    int st;
    @(posedge clock);
    if (!reset_n) begin
      model_reset();
    end else begin
      tk    = pwm_enable && ((elapsed % (MP + 1)) == MP);
      st    = (elapsed / (MP + 1)) % 255;
      bd    = tk && (st == 254);
      e_sig = pwm_enable && (st < m_active);
      e_ps  = bd;
      if (m_done) begin
        if (!pwm_update) m_done = 0;
      end else if (m_pend) begin
        if (bd || !pwm_enable) begin
          m_active = m_shadow;
          m_pend   = 0;
          m_done   = 1;
        end
      end else if (pwm_update) begin
        m_shadow = int'(pwm_ratio);
        m_pend   = 1;
      end
      elapsed = pwm_enable ? elapsed + 1 : 0;
    end
    @(negedge clock);
    chk1("pwm_signal", pwm_signal, e_sig);
    chk1("period_start", period_start, e_ps);
    chk1("pwm_done", pwm_done, m_done);
  endtask

  task automatic request(input logic [7:0] r);
    int lat;
    pwm_update = 1'b1;
    pwm_ratio  = r;
    lat = 0;
    while (!pwm_done && lat < 600) begin
      cyc();
      lat++;
    end
    chk1("done_seen", pwm_done, 1'b1);
    pwm_update = 1'b0;
  endtask

  task automatic count_high(output int h);
    h = 0;
    repeat (255) begin
      cyc();
      h += int'(pwm_signal);
    end
  endtask

  task automatic run3(input logic lvl, output int n);
    n = 0;
    while (sig3 !== lvl && n < 3000) begin
      @(negedge clock);
      n++;
    end
    n = 0;
    while (sig3 === lvl && n < 3000) begin
      @(negedge clock);
      n++;
    end
  endtask

  initial begin
    int h;
    int lat;
    int ps_cnt;
    reset_n    = 1'b0;
    pwm_enable = 1'b0;
    pwm_update = 1'b0;
    pwm_ratio  = 8'd0;
    r3_n       = 1'b0;
    en3        = 1'b0;
    upd3       = 1'b0;
    rat3       = 8'd0;
    model_reset();
    #1;
    chk1("rst_signal", pwm_signal, 1'b0);
    chk1("rst_done", pwm_done, 1'b0);
    chk1("rst_pstart", period_start, 1'b0);
    repeat (3) cyc();

    // neutral waveform after reset
    reset_n    = 1'b1;
    pwm_enable = 1'b1;
    h = 0;
    ps_cnt = 0;
    repeat (510) begin
      cyc();
      h += int'(pwm_signal);
      ps_cnt += int'(period_start);
    end
    chkn("neutral_high", h, 256);
    chkn("neutral_pstart", ps_cnt, 2);

    // mid-period update to 200
    repeat (40) cyc();
    request(8'd200);
    count_high(h);
    chkn("ratio200_high", h, 200);

    request(8'd0);
    count_high(h);
    chkn("ratio0_high", h, 0);
    request(8'd255);
    count_high(h);
    chkn("ratio255_high", h, 255);

    // capture in the boundary cycle, ratio change while pending
    while (elapsed % 255 != 254) cyc();
    pwm_update = 1'b1;
    pwm_ratio  = 8'd50;
    cyc();
    pwm_ratio = 8'd10;
    lat = 1;
    while (!pwm_done && lat < 600) begin
      cyc();
      lat++;
    end
    chkn("boundary_capture_lat", lat, 256);
    pwm_update = 1'b0;
    count_high(h);
    chkn("ratio50_high", h, 50);

    // disable while pending
    repeat (30) cyc();
    pwm_update = 1'b1;
    pwm_ratio  = 8'd77;
    cyc();
    pwm_enable = 1'b0;
    lat = 0;
    while (!pwm_done && lat < 10) begin
      cyc();
      lat++;
    end
    chk1("dis_done_fast", lat <= 2, 1'b1);
    chk1("dis_signal_low", pwm_signal, 1'b0);
    pwm_update = 1'b0;
    cyc();
    pwm_enable = 1'b1;
    count_high(h);
    chkn("reenable77_high", h, 77);

    // random requester traffic against the model
    for (int i = 0; i < 6000; i++) begin
      if (!pwm_update) begin
        if (!pwm_done && !m_pend && $urandom_range(0, 99) < 3) begin
          pwm_update = 1'b1;
          case ($urandom_range(0, 5))
            0:       pwm_ratio = 8'd0;
            1:       pwm_ratio = 8'd255;
            default: pwm_ratio = 8'($urandom);
          endcase
        end
      end else if (pwm_done) begin
        pwm_update = 1'b0;
      end else begin
        if ($urandom_range(0, 999) < 3) pwm_update = 1'b0;
        if ($urandom_range(0, 9) == 0) pwm_ratio = 8'($urandom);
      end
      if ($urandom_range(0, 999) < 3) pwm_enable = ~pwm_enable;
      cyc();
    end

    // prescaled instance: ratio 64, then async reset mid-high
    r3_n = 1'b1;
    en3  = 1'b1;
    upd3 = 1'b1;
    rat3 = 8'd64;
    lat = 0;
    while (!done3 && lat < 1200) begin
      @(negedge clock);
      lat++;
    end
    chk1("p3_done_seen", done3, 1'b1);
    upd3 = 1'b0;
    run3(1'b1, h);
    chkn("p3_ratio64_high", h, 256);
    run3(1'b0, h);
    chkn("p3_ratio64_low", h, 764);
    repeat (100) @(negedge clock);
    chk1("p3_in_high", sig3, 1'b1);
    #2 r3_n = 1'b0;
    #1;
    chk1("p3_rst_signal", sig3, 1'b0);
    chk1("p3_rst_done", done3, 1'b0);
    chk1("p3_rst_pstart", ps3, 1'b0);
    @(negedge clock);
    r3_n = 1'b1;
    run3(1'b1, h);
    chkn("p3_neutral_high", h, 512);
    run3(1'b0, h);
    chkn("p3_neutral_low", h, 508);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
